// File: rtl/scr1_tcm_port_ctrl.sv
// Dual-port TCM controller: IMEM fetches on port A, DMEM loads/stores on port B.
// Single-cycle accept, registered response one cycle later, no stalls.
module scr1_tcm_port_ctrl #(
  parameter logic [31:0] SCR1_SIZE = 32'h00010000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          imem_req,
  output logic          imem_req_ack,
  input  logic [31:0]   imem_addr,
  output logic [31:0]   imem_rdata,
  output logic [1:0]    imem_resp,
  input  logic          dmem_req,
  output logic          dmem_req_ack,
  input  logic          dmem_cmd,
  input  logic [1:0]    dmem_width,
  input  logic [31:0]   dmem_addr,
  input  logic [31:0]   dmem_wdata,
  output logic [31:0]   dmem_rdata,
  output logic [1:0]    dmem_resp,
  output logic          mem_rena,
  output logic [$clog2(SCR1_SIZE)-3:0] mem_addra,
  input  logic [31:0]   mem_qa,
  output logic          mem_renb,
  output logic          mem_wenb,
  output logic [3:0]    mem_webb,
  output logic [$clog2(SCR1_SIZE)-3:0] mem_addrb,
  output logic [31:0]   mem_datab,
  input  logic [31:0]   mem_qb
);

  localparam int AW = $clog2(SCR1_SIZE);

  typedef enum logic [1:0] {
    K_RD  = 2'd0,
    K_WR  = 2'd1,
    K_ERR = 2'd2
  } kind_e;

  // Upper address bits alias onto the TCM and are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^{imem_addr[31:AW], dmem_addr[31:AW]};

  assign imem_req_ack = rst_n;
  assign dmem_req_ack = rst_n;

  // IMEM port
  logic i_acc;
  logic i_ok;
  logic iv_d, iv_q;
  logic ierr_d, ierr_q;

  assign i_acc     = rst_n & imem_req;
  assign i_ok      = (imem_addr[1:0] == 2'b00);
  assign mem_rena  = i_acc & i_ok;
  assign mem_addra = imem_addr[AW-1:2];
  assign iv_d      = i_acc;
  assign ierr_d    = ~i_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iv_q   <= 1'b0;
      ierr_q <= 1'b0;
    end else begin
      iv_q   <= iv_d;
      ierr_q <= ierr_d;
    end
  end

  assign imem_resp  = !iv_q  ? 2'b00 :
                      ierr_q ? 2'b10 : 2'b01;
  assign imem_rdata = (iv_q && !ierr_q) ? mem_qa : '0;

  // DMEM port
  logic [1:0] off;
  logic       d_legal;
  logic [3:0] be;
  logic       d_acc;
  logic       d_go;

  assign off = dmem_addr[1:0];

  always_comb begin
    d_legal = 1'b0;
    be      = 4'b0000;
    unique case (dmem_width)
      2'b00: begin
        d_legal = 1'b1;
        be      = 4'b0001 << off;
      end
      2'b01: begin
        d_legal = ~off[0];
        be      = 4'b0011 << off;
      end
      2'b10: begin
        d_legal = (off == 2'b00);
        be      = 4'b1111;
      end
      default: begin
        d_legal = 1'b0;
        be      = 4'b0000;
      end
    endcase
  end

  assign d_acc     = rst_n & dmem_req;
  assign d_go      = d_acc & d_legal;
  assign mem_renb  = d_go & ~dmem_cmd;
  assign mem_wenb  = d_go & dmem_cmd;
  assign mem_webb  = mem_wenb ? be : 4'b0000;
  assign mem_addrb = dmem_addr[AW-1:2];
  assign mem_datab = dmem_wdata << {off, 3'b000};

  logic       dv_d, dv_q;
  kind_e      dk_d, dk_q;
  logic [1:0] doff_q;
  logic [1:0] dwid_q;

  assign dv_d = d_acc;
  assign dk_d = !d_legal ? K_ERR :
                dmem_cmd ? K_WR  : K_RD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q   <= 1'b0;
      dk_q   <= K_RD;
      doff_q <= 2'b00;
      dwid_q <= 2'b00;
    end else begin
      dv_q   <= dv_d;
      dk_q   <= dk_d;
      doff_q <= off;
      dwid_q <= dmem_width;
    end
  end

  logic [31:0] rd_sh;
  logic [31:0] rd_mask;

  assign rd_sh   = mem_qb >> {doff_q, 3'b000};
  assign rd_mask = (dwid_q == 2'b00) ? 32'h0000_00FF :
                   (dwid_q == 2'b01) ? 32'h0000_FFFF :
                                       32'hFFFF_FFFF;

  assign dmem_resp  = !dv_q           ? 2'b00 :
                      (dk_q == K_ERR) ? 2'b10 : 2'b01;
  assign dmem_rdata = (dv_q && dk_q == K_RD) ? (rd_sh & rd_mask) : '0;

endmodule

// File: tb/tb_scr1_tcm_port_ctrl.sv
// Bench for scr1_tcm_port_ctrl: behavioural dual-port RAM plus a byte-level
// reference memory feeding per-port response queues.
module tb_scr1_tcm_port_ctrl;

  localparam logic [31:0] SIZE = 32'h00010000;
  localparam int AW = 16;
  localparam int NW = 16384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req = 1'b0;
  logic        imem_req_ack;
  logic [31:0] imem_addr = '0;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_resp;
  logic        dmem_req = 1'b0;
  logic        dmem_req_ack;
  logic        dmem_cmd = 1'b0;
  logic [1:0]  dmem_width = '0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic [31:0] dmem_rdata;
  logic [1:0]  dmem_resp;
  logic        mem_rena;
  logic [AW-3:0] mem_addra;
  logic [31:0] mem_qa = '0;
  logic        mem_renb;
  logic        mem_wenb;
  logic [3:0]  mem_webb;
  logic [AW-3:0] mem_addrb;
  logic [31:0] mem_datab;
  logic [31:0] mem_qb = '0;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_i[$];
  exp_t sb_d[$];

  logic [31:0] ram [0:NW-1];
  logic [31:0] ref_mem [0:NW-1];

  always #5 clk = ~clk;

  scr1_tcm_port_ctrl #(.SCR1_SIZE(SIZE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_req_ack (imem_req_ack),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .dmem_req     (dmem_req),
    .dmem_req_ack (dmem_req_ack),
    .dmem_cmd     (dmem_cmd),
    .dmem_width   (dmem_width),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .mem_rena     (mem_rena),
    .mem_addra    (mem_addra),
    .mem_qa       (mem_qa),
    .mem_renb     (mem_renb),
    .mem_wenb     (mem_wenb),
    .mem_webb     (mem_webb),
    .mem_addrb    (mem_addrb),
    .mem_datab    (mem_datab),
    .mem_qb       (mem_qb)
  );

  // Synchronous RAM: read data one cycle after enable, read-before-write.
  always @(posedge clk) begin
    if (mem_rena) mem_qa <= ram[mem_addra];
    if (mem_renb) mem_qb <= ram[mem_addrb];
    for (int b = 0; b < 4; b++)
      if (mem_wenb && mem_webb[b])
        ram[mem_addrb][8*b +: 8] <= mem_datab[8*b +: 8];
  end

  // Response monitor: one expected entry per port per accepted cycle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_i.size() > 0) begin
      e = sb_i.pop_front();
      total++;
      if (imem_resp !== e.resp) begin
        bad++;
        $display("FAIL imem_resp got %b exp %b @%0t", imem_resp, e.resp, $time);
      end
      total++;
      if (imem_rdata !== e.rdata) begin
        bad++;
        $display("FAIL imem_rdata got %h exp %h @%0t", imem_rdata, e.rdata, $time);
      end
    end
    if (sb_d.size() > 0) begin
      e = sb_d.pop_front();
      total++;
      if (dmem_resp !== e.resp) begin
        bad++;
        $display("FAIL dmem_resp got %b exp %b @%0t", dmem_resp, e.resp, $time);
      end
      total++;
      if (dmem_rdata !== e.rdata) begin
        bad++;
        $display("FAIL dmem_rdata got %h exp %h @%0t", dmem_rdata, e.rdata, $time);
      end
    end
  end

  task automatic drive(input logic ireq, input logic [31:0] iaddr,
                       input logic dreq, input logic dcmd,
                       input logic [1:0] dwid, input logic [31:0] daddr,
                       input logic [31:0] dwdata);
    exp_t ei;
    exp_t ed;
    int nb;
    int off;
    int wi;
    logic [31:0] v;
    @(negedge clk);
    imem_req   = ireq;
    imem_addr  = iaddr;
    dmem_req   = dreq;
    dmem_cmd   = dcmd;
    dmem_width = dwid;
    dmem_addr  = daddr;
    dmem_wdata = dwdata;
    ei = '0;
    if (ireq) begin
      if (iaddr[1:0] != 2'b00) ei = {2'b10, 32'h0};
      else ei = {2'b01, ref_mem[int'(iaddr[AW-1:2])]};
    end
    sb_i.push_back(ei);
    nb  = (dwid == 2'd0) ? 1 : (dwid == 2'd1) ? 2 : (dwid == 2'd2) ? 4 : 0;
    off = int'(daddr[1:0]);
    wi  = int'(daddr[AW-1:2]);
    ed  = '0;
    if (dreq) begin
      if (nb == 0 || (off % nb) != 0) begin
        ed = {2'b10, 32'h0};
      end else if (dcmd) begin
        for (int k = 0; k < nb; k++)
          ref_mem[wi][8*(off+k) +: 8] = dwdata[8*k +: 8];
        ed = {2'b01, 32'h0};
      end else begin
        v = '0;
        for (int k = 0; k < nb; k++)
          v[8*k +: 8] = ref_mem[wi][8*(off+k) +: 8];
        ed = {2'b01, v};
      end
    end
    sb_d.push_back(ed);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    imem_req   = 1'b1;
    dmem_req   = 1'b1;
    dmem_cmd   = 1'b1;
    dmem_width = 2'b10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({imem_req_ack, dmem_req_ack} !== 2'b00) begin
      bad++;
      $display("FAIL rst_acks got %b exp 00", {imem_req_ack, dmem_req_ack});
    end
    total++;
    if ({mem_rena, mem_renb, mem_wenb, mem_webb} !== 7'b0) begin
      bad++;
      $display("FAIL rst_enables got %b exp 0", {mem_rena, mem_renb, mem_wenb, mem_webb});
    end
    total++;
    if ({imem_resp, dmem_resp, imem_rdata, dmem_rdata} !== 68'b0) begin
      bad++;
      $display("FAIL rst_resp got %b/%b %h/%h exp 0", imem_resp, dmem_resp, imem_rdata, dmem_rdata);
    end
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_cmd = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    total++;
    if ({imem_req_ack, dmem_req_ack} !== 2'b11) begin
      bad++;
      $display("FAIL ack_high got %b exp 11", {imem_req_ack, dmem_req_ack});
    end
  endtask

  task automatic test_fetch();
    drive(1'b1, 32'h100, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    total++;
    if (mem_rena !== 1'b1 || mem_addra !== 14'h40) begin
      bad++;
      $display("FAIL fetch_port_a got %b/%h exp 1/0040", mem_rena, mem_addra);
    end
    drive(1'b1, 32'h102, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    total++;
    if (mem_rena !== 1'b0) begin
      bad++;
      $display("FAIL fetch_misaligned_rena got %b exp 0", mem_rena);
    end
    drive(1'b1, 32'hFFFF_0104, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    total++;
    if (mem_addra !== 14'h41) begin
      bad++;
      $display("FAIL fetch_alias got %h exp 0041", mem_addra);
    end
    idle();
  endtask

  task automatic test_write();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 2'b00, 32'h203, 32'h0000_00A5);
    total++;
    if ({mem_wenb, mem_renb, mem_webb} !== 6'b10_1000) begin
      bad++;
      $display("FAIL wr_byte_en got %b exp 101000", {mem_wenb, mem_renb, mem_webb});
    end
    total++;
    if (mem_datab !== 32'hA500_0000 || mem_addrb !== 14'h80) begin
      bad++;
      $display("FAIL wr_byte_data got %h/%h exp a5000000/0080", mem_datab, mem_addrb);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1, 2'b01, 32'h206, 32'h0000_BEEF);
    total++;
    if (mem_webb !== 4'b1100 || mem_datab !== 32'hBEEF_0000) begin
      bad++;
      $display("FAIL wr_half got %b/%h exp 1100/beef0000", mem_webb, mem_datab);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1, 2'b10, 32'h100, 32'h1234_ABCD);
    total++;
    if (mem_webb !== 4'b1111 || mem_datab !== 32'h1234_ABCD) begin
      bad++;
      $display("FAIL wr_word got %b/%h exp 1111/1234abcd", mem_webb, mem_datab);
    end
    idle();
  endtask

  task automatic test_read();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 2'b01, 32'h102, 32'h0);
    total++;
    if ({mem_renb, mem_wenb, mem_webb} !== 6'b10_0000) begin
      bad++;
      $display("FAIL rd_en got %b exp 100000", {mem_renb, mem_wenb, mem_webb});
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 2'b00, 32'h203, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 2'b00, 32'h101, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 32'h204, 32'h0);
    idle();
  endtask

  task automatic test_errors();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 32'h102, 32'h0);
    total++;
    if ({mem_renb, mem_wenb} !== 2'b00) begin
      bad++;
      $display("FAIL err_word_mis got %b exp 00", {mem_renb, mem_wenb});
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1, 2'b11, 32'h100, 32'hFFFF_FFFF);
    total++;
    if ({mem_renb, mem_wenb, mem_webb} !== 6'b0) begin
      bad++;
      $display("FAIL err_width11 got %b exp 0", {mem_renb, mem_wenb, mem_webb});
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1, 2'b01, 32'h101, 32'h0000_5555);
    total++;
    if (mem_wenb !== 1'b0) begin
      bad++;
      $display("FAIL err_half_mis got %b exp 0", mem_wenb);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
    idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++)
      drive(1'b1, 32'h0, 1'b1, 1'b0, 2'b10, 32'h4, 32'h0);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ia;
      logic [31:0] da;
      ia = {$urandom_range(0, 3) == 0 ? 16'hA5A5 : 16'h0, 8'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 7) == 0) ia[1:0] = 2'($urandom_range(1, 3));
      da = {$urandom} & 32'hF000_00FF;
      drive(1'($urandom_range(0, 3) != 0), ia,
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), da, $urandom);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 32'h8, 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (dmem_resp !== 2'b00 || dmem_rdata !== 32'h0) begin
      bad++;
      $display("FAIL midrst_resp got %b/%h exp 00/0", dmem_resp, dmem_rdata);
    end
    total++;
    if ({dmem_req_ack, mem_renb} !== 2'b00) begin
      bad++;
      $display("FAIL midrst_gate got %b exp 00", {dmem_req_ack, mem_renb});
    end
    @(negedge clk);
    dmem_req = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    idle();
    idle();
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      ram[i]     = i * 32'h9E37_79B9 ^ 32'h5A5A_0F0F;
      ref_mem[i] = i * 32'h9E37_79B9 ^ 32'h5A5A_0F0F;
    end
    ram[16'h40]     = 32'hDEAD_BEEF;
    ref_mem[16'h40] = 32'hDEAD_BEEF;
    test_reset();
    test_fetch();
    test_write();
    test_read();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    idle();
    @(posedge clk);
    #3;
    total++;
    if (sb_i.size() != 0 || sb_d.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got %0d/%0d exp 0/0", sb_i.size(), sb_d.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
